control_transaccion: RTL
========================

# control_transaccion

Sequencing controller for the transaction layer. Drains the main FIFO and routes each 12-bit word into one of four per-destination (blue) FIFOs, selected by the word's two MSBs, with almost-full backpressure. It owns the FIFO threshold configuration through an init/idle state machine and optionally keeps per-destination packet counters readable through a req/idx port.

## Interface

Parameters:

- `DATA_W`, 12, word width.
- `UMB_W`, 3, threshold width (FIFO depth 8).
- `CNT_W`, 8, packet counter width.

Ports:

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `init`  in  1  request (re)configuration.
- `umbral_bajo_in`  in  UMB_W  almost-empty threshold to latch.
- `umbral_alto_in`  in  UMB_W  almost-full threshold to latch.
- `fifo_main_data`  in  DATA_W  head word of main FIFO (first-word-fall-through).
- `fifo_main_empty`  in  1  main FIFO empty.
- `fifo_main_pop`  out  1  main FIFO pop (combinational).
- `fifo_azul_almost_full`  in  4  per-destination almost-full.
- `fifo_azul_empty`  in  4  per-destination empty.
- `fifo_azul_push`  out  4  per-destination push, one-hot or zero (registered).
- `fifo_azul_data`  out  DATA_W  shared write data to blue FIFOs (registered).
- `umbral_bajo`  out  UMB_W  configured almost-empty threshold (registered).
- `umbral_alto`  out  UMB_W  configured almost-full threshold (registered).
- `estado`  out  4  one-hot FSM state.
- `idle`  out  1  system drained and in IDLE.
- `req`  in  1  counter read request (only with CONTADORES_EN).
- `idx`  in  2  counter index (only with CONTADORES_EN).
- `salida_contador`  out  CNT_W  counter read data (only with CONTADORES_EN).
- `valid_contador`  out  1  counter read valid (only with CONTADORES_EN).

## Operation

- **States (one-hot `estado`):** RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000.
- **RESET:** entered asynchronously while `reset`=0. Moves to INIT on the first edge with `init`=1; otherwise holds.
- **INIT:** `umbral_bajo`/`umbral_alto` load from the `_in` inputs on every cycle. No pops. Moves to IDLE when `init`=0.
- **IDLE:** moves to ACTIVE when `fifo_main_empty`=0. Moves to INIT when `init`=1.
- **ACTIVE:**
  - `dest` = `fifo_main_data[11:10]`.
  - `fifo_main_pop` = !`fifo_main_empty` && !`fifo_azul_almost_full[dest]` && !`init`.
  - On a pop, the next cycle drives `fifo_azul_push[dest]`=1 and `fifo_azul_data`=popped word.
  - Moves to IDLE when main is empty and no push is pending. Moves to INIT when `init`=1.
- **Head-of-line blocking:** a full destination stalls all traffic. There is no reordering.
- **init during ACTIVE:** pops stop in the same cycle. A push already pending still completes in the following cycle.
- **`idle`** = state IDLE && `fifo_main_empty` && &`fifo_azul_empty`.
- **Threshold constraint:** `umbral_alto` ≤ depth−2. One push may land after almost-full rises, because the flag lags by one cycle. The controller does not check the programmed value.
- **Reset values:** `fifo_main_pop`=0, `fifo_azul_push`=0, `fifo_azul_data`=0, `umbral_bajo`=0, `umbral_alto`=0, `estado`=0001, `idle`=0, `salida_contador`=0, `valid_contador`=0.

## Timing

- Pop-to-push latency is 1 cycle. Throughput is 1 word per cycle when unblocked.
- Back-to-back pops to different destinations are allowed.
- Thresholds are visible on the outputs 1 cycle after the INIT edge that latches them.
- Counter read: `req` sampled at edge N gives `salida_contador`=count[`idx`] and `valid_contador`=1 during cycle N+1. Otherwise `valid_contador`=0 and `salida_contador`=0.
- A counter push in the same cycle as a read returns the pre-increment value.

## Configuration

- **`CONTADORES_EN` defined:** four `CNT_W` counters, one per destination.
  - Increment on each `fifo_azul_push` bit.
  - Wrap from 255 to 0.
  - Clear on reset and on entry to INIT.
  - `req`/`idx` serviced as described under Timing.
- **`CONTADORES_EN` undefined:** counters absent; `req`/`idx` ignored; `salida_contador`=0; `valid_contador`=0.

## Test plan

- Reset low then high, `init`=0 → `estado`=0001 and all outputs 0. With `init`=1 for 2 cycles (`umbral_in` 1/6) → `umbral_bajo`=1, `umbral_alto`=6, then `estado`=0100.
- Push 0x005, 0x412, 0x823, 0xC34 into main → pushes on ports 0, 1, 2, 3 in consecutive cycles with matching data; `estado` returns to 0100; `idle`=1 once the blue FIFOs drain.
- Hold `fifo_azul_almost_full[1]`=1 with head 0x4AA → `fifo_main_pop`=0 until released, then the push to port 1 occurs 1 cycle after the pop.
- Raise `init` mid-stream → pop drops the same cycle, the pending push completes, `estado`=0010, and counters read 0 afterward.
- With `CONTADORES_EN`: push 257 words to port 2, then `req`=1, `idx`=2 → next cycle `valid_contador`=1 and `salida_contador`=1.
- Assert `reset`=0 mid-ACTIVE asynchronously → push and pop drop immediately and `estado`=0001 without a clock edge.

Source files
------------

// File: rtl/control_transaccion.sv
// rtl/control_transaccion.sv - transaction-layer sequencer: main FIFO to four blue FIFOs by word MSBs
// Optional per-destination packet counters are built when CONTADORES_EN is defined.
module control_transaccion #(
  parameter int DATA_W = 12,
  parameter int UMB_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [UMB_W-1:0]  umbral_bajo_in,
  input  logic [UMB_W-1:0]  umbral_alto_in,
  input  logic [DATA_W-1:0] fifo_main_data,
  input  logic              fifo_main_empty,
  output logic              fifo_main_pop,
  input  logic [3:0]        fifo_azul_almost_full,
  input  logic [3:0]        fifo_azul_empty,
  output logic [3:0]        fifo_azul_push,
  output logic [DATA_W-1:0] fifo_azul_data,
  output logic [UMB_W-1:0]  umbral_bajo,
  output logic [UMB_W-1:0]  umbral_alto,
  output logic [3:0]        estado,
  output logic              idle,
  input  logic              req,
  input  logic [1:0]        idx,
  output logic [CNT_W-1:0]  salida_contador,
  output logic              valid_contador
);

  typedef enum logic [3:0] {
    S_RESET  = 4'b0001,
    S_INIT   = 4'b0010,
    S_IDLE   = 4'b0100,
    S_ACTIVE = 4'b1000
  } state_t;

  state_t     state, state_next;
  logic [1:0] dest;
  logic       pop;
  logic       push_pending;

  assign dest         = fifo_main_data[DATA_W-1 -: 2];
  assign push_pending = |fifo_azul_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RESET;
    else        state <= state_next;
  end

  // Head-of-line blocking: an almost-full destination stalls the whole stream.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      S_RESET: begin
        if (init) state_next = S_INIT;
      end
      S_INIT: begin
        if (!init) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (init)                  state_next = S_INIT;
        else if (!fifo_main_empty) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        pop = !fifo_main_empty && !fifo_azul_almost_full[dest] && !init;
        if (init)                                  state_next = S_INIT;
        else if (fifo_main_empty && !push_pending) state_next = S_IDLE;
      end
      default: state_next = S_RESET;
    endcase
  end

  assign fifo_main_pop = pop;
  assign estado        = state;
  assign idle          = (state == S_IDLE) && fifo_main_empty && (&fifo_azul_empty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_azul_push <= 4'b0000;
      fifo_azul_data <= '0;
    end else begin
      fifo_azul_push <= pop ? (4'b0001 << dest) : 4'b0000;
      if (pop) fifo_azul_data <= fifo_main_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      umbral_bajo <= '0;
      umbral_alto <= '0;
    end else if (state == S_INIT) begin
      umbral_bajo <= umbral_bajo_in;
      umbral_alto <= umbral_alto_in;
    end
  end

`ifdef CONTADORES_EN
  logic [CNT_W-1:0] cnt [4];

  // Clearing on INIT entry wins over a push landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (state_next == S_INIT && state != S_INIT) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (fifo_azul_push[i]) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      salida_contador <= '0;
      valid_contador  <= 1'b0;
    end else begin
      valid_contador  <= req;
      salida_contador <= req ? cnt[idx] : '0;
    end
  end
`else
  logic unused_contador;
  assign unused_contador = ^{req, idx};
  assign salida_contador = '0;
  assign valid_contador  = 1'b0;
`endif

endmodule
